// File: rtl/array_1_port_arb.sv
// Round-robin read/write arbiter in front of one 128x128 single-port RW macro (1-cycle read).
// Define ARRAY_1_PORT_ARB_INIT_EN to zero-fill the array after every reset before accepting traffic.
module array_1_port_arb (
  input  logic         clock,
  input  logic         reset,
  // read request channel
  input  logic         rd_valid,
  output logic         rd_ready,
  input  logic [6:0]   rd_addr,
  // read response channel
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  // write request channel
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [6:0]   wr_addr,
  input  logic [3:0]   wr_mask,
  input  logic [127:0] wr_data,
  // macro port
  output logic         mem_en,
  output logic         mem_wmode,
  output logic [6:0]   mem_addr,
  output logic [3:0]   mem_wmask,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  output logic         init_done
);

  typedef enum logic [0:0] {StInit, StRun} state_e;
  typedef enum logic [0:0] {GrantRd, GrantWr} grant_e;

  state_e       state_q;
  logic         run;
  logic         init_active;
  logic [6:0]   init_addr;

  grant_e       last_grant_q, last_grant_d;
  logic         rd_inflight_q, rd_inflight_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic [127:0] rsp_data_q, rsp_data_d;

  logic         rd_elig, wr_elig;
  logic         rd_grant, wr_grant;
  logic         rd_fire, wr_fire;

`ifdef ARRAY_1_PORT_ARB_INIT_EN
  state_e     state_d;
  logic [6:0] init_cnt_q, init_cnt_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      StInit: begin
        init_cnt_d = init_cnt_q + 7'd1;
        if (init_cnt_q == 7'd127) begin
          state_d = StRun;
        end
      end
      StRun: begin
        state_d = StRun;
      end
      default: begin
        state_d = StInit;
      end
    endcase
  end

  assign init_active = (state_q == StInit) && !reset;
  assign init_addr   = init_cnt_q;
`else
  assign state_q     = StRun;
  assign init_active = 1'b0;
  assign init_addr   = 7'd0;
`endif

  assign run       = (state_q == StRun) && !reset;
  assign init_done = (state_q == StRun);

  // A read is eligible only with no read in flight and room in the response register.
  always_comb begin
    rd_elig  = run && rd_valid && !rd_inflight_q && (!rsp_valid_q || rsp_ready);
    wr_elig  = run && wr_valid;
    rd_grant = rd_elig && (!wr_elig || (last_grant_q == GrantWr));
    wr_grant = wr_elig && (!rd_elig || (last_grant_q == GrantRd));
  end

  assign rd_ready = rd_grant;
  assign wr_ready = wr_grant;
  assign rd_fire  = rd_valid && rd_ready;
  assign wr_fire  = wr_valid && wr_ready;

  always_comb begin
    last_grant_d  = last_grant_q;
    rd_inflight_d = rd_fire;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    if (rd_fire) begin
      last_grant_d = GrantRd;
    end else if (wr_fire) begin
      last_grant_d = GrantWr;
    end
    // Macro data is valid the cycle after issue; a landing response overrides a pop.
    if (rd_inflight_q) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = mem_rdata;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant_q  <= GrantWr;
      rd_inflight_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
    end else begin
      last_grant_q  <= last_grant_d;
      rd_inflight_q <= rd_inflight_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

  always_comb begin
    mem_en    = 1'b0;
    mem_wmode = 1'b0;
    mem_addr  = rd_addr;
    mem_wmask = 4'h0;
    mem_wdata = wr_data;
    if (init_active) begin
      mem_en    = 1'b1;
      mem_wmode = 1'b1;
      mem_addr  = init_addr;
      mem_wmask = 4'hF;
      mem_wdata = '0;
    end else if (wr_fire) begin
      mem_en    = 1'b1;
      mem_wmode = 1'b1;
      mem_addr  = wr_addr;
      mem_wmask = wr_mask;
    end else if (rd_fire) begin
      mem_en    = 1'b1;
      mem_addr  = rd_addr;
    end
  end

  // The macro has a single port, and only one read may be outstanding.
  a_one_access : assert property (@(posedge clock) disable iff (reset) !(rd_fire && wr_fire));
  a_no_rd_b2b : assert property (@(posedge clock) disable iff (reset) rd_inflight_q |-> !rd_fire);

endmodule
